text_vmem: RTL and testbench

Parametrised character-cell video memory between the PS/2 keyboard decoder and the VGA character generator. Accepts ASCII codes through a valid/ready handshake, maintains a write cursor with line wrap, newline, backspace and hardware scrolling, and serves a registered read port indexed by screen cell and pixel address for the font ROM lookup. Memory is cleared by a sweep after reset and by a row sweep on each scroll.

---
 rtl/text_vmem.sv | 188 ++++++++++++++++++
 tb/tb_text_vmem.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/text_vmem.sv
// Character-cell video memory: keyboard write port with cursor, wrap and scrolling,
// registered read port for the font lookup. Optional blinking cursor: TEXT_VMEM_CURSOR_EN.
module text_vmem #(
  parameter int unsigned COLS         = 70,
  parameter int unsigned ROWS         = 30,
  parameter int unsigned CHAR_W       = 9,
  parameter int unsigned CHAR_H       = 16,
  parameter int unsigned BLINK_CYCLES = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              key_in,
  input  logic                    p_valid,
  output logic                    p_ready,
  input  logic [$clog2(COLS)-1:0] x,
  input  logic [$clog2(ROWS)-1:0] y,
  input  logic [9:0]              h_addr,
  input  logic [9:0]              v_addr,
  output logic [7:0]              ascii_out,
  output logic [3:0]              row,
  output logic [3:0]              col,
  output logic [$clog2(COLS)-1:0] cur_x,
  output logic [$clog2(ROWS)-1:0] cur_y
);
  localparam int unsigned XW    = $clog2(COLS);
  localparam int unsigned YW    = $clog2(ROWS);
  localparam int unsigned DEPTH = COLS * ROWS;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {INIT_CLR, IDLE, LINE_CLR} state_t;

  state_t          state, state_nxt;
  logic [XW-1:0]   cur_x_nxt;
  logic [YW-1:0]   cur_y_nxt, top, top_nxt, clr_row, clr_row_nxt;
  logic [AW-1:0]   clr_cnt, clr_cnt_nxt;
  logic            we, adv;
  logic [AW-1:0]   waddr, rd_addr;
  logic [7:0]      wdata, rd_data;
  logic            rd_ok;
  logic [7:0]      mem [DEPTH];

  // Logical (row, column) to physical address through the scroll offset.
  function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] t,
                                              input logic [YW-1:0] lrow,
                                              input logic [XW-1:0] c);
    logic [YW:0] s;
    s = {1'b0, t} + {1'b0, lrow};
    if (s >= (YW+1)'(ROWS)) s = s - (YW+1)'(ROWS);
    return AW'(s) * AW'(COLS) + AW'(c);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= INIT_CLR;
      p_ready <= 1'b0;
      cur_x   <= '0;
      cur_y   <= '0;
      top     <= '0;
      clr_row <= '0;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      p_ready <= (state_nxt == IDLE);
      cur_x   <= cur_x_nxt;
      cur_y   <= cur_y_nxt;
      top     <= top_nxt;
      clr_row <= clr_row_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cur_x_nxt   = cur_x;
    cur_y_nxt   = cur_y;
    top_nxt     = top;
    clr_row_nxt = clr_row;
    clr_cnt_nxt = clr_cnt;
    we          = 1'b0;
    waddr       = '0;
    wdata       = 8'h00;
    adv         = 1'b0;
    case (state)
      INIT_CLR: begin
        we    = 1'b1;
        waddr = clr_cnt;
        if (clr_cnt == AW'(DEPTH - 1)) begin
          state_nxt   = IDLE;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + AW'(1);
        end
      end
      LINE_CLR: begin
        we    = 1'b1;
        waddr = AW'(clr_row) * AW'(COLS) + clr_cnt;
        if (clr_cnt == AW'(COLS - 1)) begin
          state_nxt   = IDLE;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + AW'(1);
        end
      end
      default: begin
        if (p_valid) begin
          if (key_in == 8'h00) begin
            adv = 1'b0;
          end else if (key_in == 8'h0A || key_in == 8'h0D) begin
            cur_x_nxt = '0;
            adv       = 1'b1;
          end else if (key_in == 8'h08) begin
            if (cur_x != '0) begin
              cur_x_nxt = cur_x - XW'(1);
            end else if (cur_y != '0) begin
              cur_x_nxt = XW'(COLS - 1);
              cur_y_nxt = cur_y - YW'(1);
            end
            we    = 1'b1;
            waddr = cell_addr(top, cur_y_nxt, cur_x_nxt);
          end else begin
            we    = 1'b1;
            waddr = cell_addr(top, cur_y, cur_x);
            wdata = key_in;
            if (cur_x == XW'(COLS - 1)) begin
              cur_x_nxt = '0;
              adv       = 1'b1;
            end else begin
              cur_x_nxt = cur_x + XW'(1);
            end
          end
          // Bottom row full: scroll and wipe the row that becomes the new bottom.
          if (adv) begin
            if (cur_y < YW'(ROWS - 1)) begin
              cur_y_nxt = cur_y + YW'(1);
            end else begin
              top_nxt     = (top == YW'(ROWS - 1)) ? '0 : top + YW'(1);
              clr_row_nxt = top;
              clr_cnt_nxt = '0;
              state_nxt   = LINE_CLR;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef TEXT_VMEM_CURSOR_EN
  logic [31:0] blink_cnt;
  logic        blink_on;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == 32'(BLINK_CYCLES - 1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    rd_ok   = (32'(x) < COLS) && (32'(y) < ROWS);
    rd_addr = rd_ok ? cell_addr(top, y, x) : '0;
    rd_data = rd_ok ? mem[rd_addr] : 8'h00;
`ifdef TEXT_VMEM_CURSOR_EN
    if (blink_on && x == cur_x && y == cur_y) rd_data = 8'h5F;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ascii_out <= 8'h00;
      row       <= 4'h0;
      col       <= 4'h0;
    end else begin
      ascii_out <= rd_data;
      row       <= 4'(v_addr - 10'(y) * 10'(CHAR_H));
      col       <= 4'(h_addr - 10'(x) * 10'(CHAR_W));
    end
  end
endmodule

// File: tb/tb_text_vmem.sv
// Directed bench for text_vmem: init sweep, writes, wrap, backspace, scroll, reset, blink.
module tb_text_vmem;
  localparam int unsigned COLS = 70;
  localparam int unsigned ROWS = 30;
  localparam int unsigned XW   = $clog2(COLS);
  localparam int unsigned YW   = $clog2(ROWS);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    key_in = 8'h00;
  logic          p_valid = 1'b0;
  logic          p_ready;
  logic [XW-1:0] x = '0;
  logic [YW-1:0] y = '0;
  logic [9:0]    h_addr = '0;
  logic [9:0]    v_addr = '0;
  logic [7:0]    ascii_out;
  logic [3:0]    row, col;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  text_vmem #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(9), .CHAR_H(16), .BLINK_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .p_valid(p_valid), .p_ready(p_ready),
    .x(x), .y(y), .h_addr(h_addr), .v_addr(v_addr), .ascii_out(ascii_out),
    .row(row), .col(col), .cur_x(cur_x), .cur_y(cur_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] k);
    int n = 0;
    while (!p_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!p_ready) check("send_timeout", 32'(p_ready), 32'd1);
    key_in  = k;
    p_valid = 1'b1;
    @(negedge clk);
    p_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input int cx, input int cy, input logic [7:0] exp);
    x = XW'(cx);
    y = YW'(cy);
    @(negedge clk);
    check(tag, 32'(ascii_out), 32'(exp));
  endtask

  task automatic cur(input string tag, input int ex, input int ey);
    check({tag, "_x"}, 32'(cur_x), 32'(ex));
    check({tag, "_y"}, 32'(cur_y), 32'(ey));
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles);
    int n = 0;
    while (!p_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_cycles >= 0) check(tag, 32'(n), 32'(exp_cycles));
    else if (!p_ready) check(tag, 32'(p_ready), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(p_ready), 32'd0);
    check("rst_ascii", 32'(ascii_out), 32'd0);
    check("rst_row", 32'(row), 32'd0);
    check("rst_col", 32'(col), 32'd0);
    cur("rst_cur", 0, 0);

    reset = 1'b1;
    wait_ready("init_len", 2100);
    rd("init_00", 0, 0, 8'h00);
    rd("init_69_29", 69, 29, 8'h00);

    // First character, pixel-address arithmetic
    send(8'h41);
    cur("a_cur", 1, 0);
    rd("a_rd", 0, 0, 8'h41);
    h_addr = 10'd20; v_addr = 10'd37; x = XW'(2); y = YW'(2);
    @(negedge clk);
    check("col_2", 32'(col), 32'd2);
    check("row_5", 32'(row), 32'd5);
    h_addr = 10'd0; v_addr = 10'd3; x = XW'(1); y = YW'(1);
    @(negedge clk);
    check("col_wrap", 32'(col), 32'd7);
    check("row_wrap", 32'(row), 32'd3);

    // Same-cycle read and write of one cell returns old data
    x = XW'(1); y = YW'(0);
    @(negedge clk);
    send(8'h42);
    check("rw_old", 32'(ascii_out), 32'h00);
    @(negedge clk);
    check("rw_new", 32'(ascii_out), 32'h42);
    for (int i = 0; i < 68; i++) send(8'h42);
    cur("wrap_cur", 0, 1);
    send(8'h43);
    cur("c_cur", 1, 1);
    rd("c_rd", 0, 1, 8'h43);
    rd("b_rd", 69, 0, 8'h42);
    rd("oor_x", 70, 0, 8'h00);
    rd("oor_y", 0, 31, 8'h00);
    send(8'h00);
    cur("nul_cur", 1, 1);

    // Backspace within a row and across rows
    send(8'h08);
    cur("bs1_cur", 0, 1);
    rd("bs1_rd", 0, 1, 8'h00);
    send(8'h08);
    cur("bs2_cur", 69, 0);
    rd("bs2_rd", 69, 0, 8'h00);
    rd("bs2_keep", 68, 0, 8'h42);
    send(8'h5A);
    cur("z_cur", 0, 1);
    rd("z_rd", 69, 0, 8'h5A);

    // Newlines to the bottom row then scroll
    for (int i = 0; i < 28; i++) send(8'h0A);
    cur("nl_cur", 0, 29);
    send(8'h44);
    cur("d_cur", 1, 29);
    send(8'h0D);
    wait_ready("scroll_len", 70);
    cur("scr_cur", 0, 29);
    rd("scr_d", 0, 28, 8'h44);
    rd("scr_clr1", 1, 29, 8'h00);
    rd("scr_clr69", 69, 29, 8'h00);
    rd("scr_row0", 0, 0, 8'h00);

    // Reset mid-run while a character is offered during the sweep
    reset = 1'b0;
    @(negedge clk);
    check("rst2_ready", 32'(p_ready), 32'd0);
    cur("rst2_cur", 0, 0);
    key_in = 8'h41; p_valid = 1'b1;
    reset = 1'b1;
    repeat (50) @(negedge clk);
    check("blocked_cur", 32'(cur_x), 32'd0);
    p_valid = 1'b0;
    wait_ready("init2", -1);
    cur("init2_cur", 0, 0);
    rd("init2_d", 0, 28, 8'h00);
    rd("init2_00", 0, 0, 8'h00);
    send(8'h08);
    cur("bs0_cur", 0, 0);

`ifdef TEXT_VMEM_CURSOR_EN
    x = XW'(0); y = YW'(0);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      check("blink", 32'(ascii_out), ((((cyc - 1) / 4) % 2) == 0) ? 32'h5F : 32'h00);
      @(negedge clk);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
